// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_lsu_pkg                                                     |
// | Shared constants for the data-memory load/store unit: funct3     |
// | codes, FSM state encoding, region tags and memory type code.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dmem_lsu_pkg;

   // RV32I load funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // RV32I store funct3 codes
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // addr[31:18] region tags
   localparam logic [13:0] DMEM_TAG = 14'h2000;
   localparam logic [13:0] SROM_TAG = 14'h0004;

   // Memory port always moves whole words
   localparam logic [2:0] MEM_TYPE_WORD = 3'b010;

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_lane_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_lane_align                                                   |
// | Combinational byte-lane logic: load extraction with sign/zero    |
// | extension, and store merge of a byte/half into an existing word. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lsu_lane_align
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Pick the addressed lane and extend it according to the load type
   always_comb begin
      byte_lane = word[{addr_lo, 3'b000} +: 8];
      half_lane = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
         F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
         F3_LW:   load_data = word;
         F3_LBU:  load_data = {24'h0, byte_lane};
         F3_LHU:  load_data = {16'h0, half_lane};
         default: load_data = 32'h0;
      endcase
   end

   // Overwrite only the addressed lane; other bytes keep the read word
   always_comb begin
      merged = word;
      case (funct3)
         F3_SB: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         F3_SH: begin
            if (addr_lo[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_lsu                                                         |
// | Load/store unit between the RV32I execute stage and a word-wide  |
// | data memory. Byte/half loads are extracted locally; byte/half    |
// | stores use read-modify-write. Illegal accesses are rejected.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_lsu
   import dmem_lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_type,
   input  logic [31:0] mem_rdata
);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [31:0] merged_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic        err_q;
   logic        req_err;
   logic        req_is_sw;
   logic        in_dmem;
   logic        in_srom;
   logic        f3_ok;
   logic [31:0] lane_load;
   logic [31:0] lane_merged;

   lsu_lane_align u_lane_align (
      .word      (mem_rdata),
      .wdata     (wdata_q),
      .addr_lo   (addr_q[1:0]),
      .funct3    (f3_q),
      .load_data (lane_load),
      .merged    (lane_merged)
   );

   // Classify the incoming request; any error skips the memory entirely
   always_comb begin
      in_dmem   = (req_addr[31:18] == DMEM_TAG);
      in_srom   = (req_addr[31:18] == SROM_TAG);
      req_is_sw = req_we && (req_funct3 == F3_SW);
      if (req_we) f3_ok = req_funct3 inside {F3_SB, F3_SH, F3_SW};
      else        f3_ok = req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      // funct3[1:0]==01 covers LH/LHU/SH, ==10 covers LW/SW
      req_err = !f3_ok
             || ((req_funct3[1:0] == 2'b01) && req_addr[0])
             || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
             || !(in_dmem || in_srom)
             || (req_we && in_srom);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state selection
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_err)        state_nxt = ST_RESP;
               else if (req_is_sw) state_nxt = ST_WR;
               else                state_nxt = ST_RD;
            end
         end
         ST_RD:   state_nxt = we_q ? ST_WR : ST_RESP;
         ST_WR:   state_nxt = ST_RESP;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request capture at accept, read-data capture in RD
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         merged_q <= 32'h0;
         we_q     <= 1'b0;
         f3_q     <= 3'b000;
         err_q    <= 1'b0;
      end else if ((state == ST_IDLE) && req_valid) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         we_q    <= req_we;
         f3_q    <= req_funct3;
         err_q   <= req_err;
         rdata_q <= 32'h0;
      end else if (state == ST_RD) begin
         if (we_q) merged_q <= lane_merged;
         else      rdata_q  <= lane_load;
      end
   end

   // Outputs decoded from state; strobes gated by reset so an aborting edge never writes
   always_comb begin
      req_ready  = (state == ST_IDLE);
      resp_valid = (state == ST_RESP);
      resp_rdata = (state == ST_RESP) ? rdata_q : 32'h0;
      resp_err   = (state == ST_RESP) && err_q;
      mem_read   = (state == ST_RD) && rst_n;
      mem_write  = (state == ST_WR) && rst_n;
      mem_addr   = ((state == ST_RD) || (state == ST_WR)) ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_wdata  = 32'h0;
      if (state == ST_WR) mem_wdata = (f3_q == F3_SW) ? wdata_q : merged_q;
      mem_type   = MEM_TYPE_WORD;
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_lsu                                                      |
// | Directed self-checking bench for dmem_lsu with a byte-level      |
// | reference model of RAM/ROM and a word-wide memory device.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_type;
   logic [31:0] mem_rdata;

   logic [31:0] dram [0:63];
   logic [31:0] srom [0:3];
   logic [7:0]  m_dram [0:255];
   logic [7:0]  m_srom [0:15];

   int checks = 0;
   int passes = 0;

   dmem_lsu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_type   (mem_type),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Word-wide memory device: combinational read, write on the clock edge
   assign mem_rdata = (mem_addr[31:18] == 14'h2000) ? dram[mem_addr[7:2]] :
                      (mem_addr[31:18] == 14'h0004) ? srom[mem_addr[3:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_write && (mem_addr[31:18] == 14'h2000)) dram[mem_addr[7:2]] <= mem_wdata;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // 0 = unmapped, 1 = RAM, 2 = ROM
   function automatic int region(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a <= 32'h8003_FFFF) return 1;
      if (a >= 32'h0010_0000 && a <= 32'h0013_FFFF) return 2;
      return 0;
   endfunction

   function automatic logic [7:0] mb(input logic [31:0] a);
      if (region(a) == 1) return m_dram[a[7:0]];
      if (region(a) == 2) return m_srom[a[3:0]];
      return 8'h0;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [31:0] w;
      w = 32'h0;
      for (int i = 0; i < 4; i++) w = w | ({24'h0, mb({a[31:2], 2'b00} + i)} << (8 * i));
      return w;
   endfunction

   // Issue one request (called at a negedge) and check every cycle up to the response
   task automatic do_op(input string nm, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit has_lit, input logic [31:0] lit, input bit lit_err);
      int          size;
      bit          legal;
      logic [31:0] exp_rd;
      logic [31:0] exp_word;
      int          exp_lat;
      int          exp_reads;
      int          exp_writes;
      int          cyc;
      int          rd;
      int          wr;
      bit          done;

      size = 1 << f3[1:0];
      if (we) legal = f3 inside {3'd0, 3'd1, 3'd2};
      else    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      if ((a % size) != 0)          legal = 0;
      if (region(a) == 0)           legal = 0;
      if (we && region(a) == 2)     legal = 0;

      exp_rd   = 32'h0;
      exp_word = 32'h0;
      if (legal && !we) begin
         for (int i = 0; i < size; i++) exp_rd = exp_rd | ({24'h0, mb(a + i)} << (8 * i));
         if (!f3[2] && size < 4 && exp_rd[8 * size - 1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * size));
      end
      if (legal && we) begin
         for (int i = 0; i < size; i++) m_dram[8'(a + i)] = 8'(wd >> (8 * i));
         exp_word = model_word(a);
      end
      exp_lat    = !legal ? 1 : (we && size < 4) ? 3 : 2;
      exp_reads  = (legal && (!we || size < 4)) ? 1 : 0;
      exp_writes = (legal && we) ? 1 : 0;

      check({nm, " ready before"}, req_ready, 1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(negedge clk);
      // Garbage on the request bus while busy must be ignored
      req_valid  = 1'b1;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h5A5A_5A5A;
      req_funct3 = 3'b111;
      cyc = 1; rd = 0; wr = 0; done = 0;
      while (!done && cyc <= 8) begin
         check({nm, " ready busy"}, req_ready, 0);
         check({nm, " type"}, mem_type, 3'b010);
         if (mem_read) begin
            rd++;
            check({nm, " rd addr"}, mem_addr, {a[31:2], 2'b00});
         end
         if (mem_write) begin
            wr++;
            check({nm, " wr addr"}, mem_addr, {a[31:2], 2'b00});
            check({nm, " wr data"}, mem_wdata, exp_word);
            if (has_lit) check({nm, " wr data lit"}, mem_wdata, lit);
         end
         if (resp_valid) begin
            done = 1;
            check({nm, " latency"}, cyc, exp_lat);
            check({nm, " rdata"}, resp_rdata, exp_rd);
            check({nm, " err"}, resp_err, !legal);
            if (has_lit) begin
               check({nm, " err lit"}, resp_err, lit_err);
               if (!we) check({nm, " rdata lit"}, resp_rdata, lit);
            end
         end else begin
            if (cyc == 1) req_valid = 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      req_valid = 1'b0;
      if (!done) check({nm, " timeout"}, 0, 1);
      check({nm, " reads"}, rd, exp_reads);
      check({nm, " writes"}, wr, exp_writes);
      @(negedge clk);
      check({nm, " ready after"}, req_ready, 1);
      check({nm, " resp drop"}, resp_valid, 0);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, " ready"}, req_ready, 1);
      check({nm, " resp_valid"}, resp_valid, 0);
      check({nm, " resp_rdata"}, resp_rdata, 0);
      check({nm, " resp_err"}, resp_err, 0);
      check({nm, " mem_read"}, mem_read, 0);
      check({nm, " mem_write"}, mem_write, 0);
      check({nm, " mem_addr"}, mem_addr, 0);
      check({nm, " mem_wdata"}, mem_wdata, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) dram[i] = 32'hA500_0000 | i;
      dram[2] = 32'h0000_0088;
      dram[4] = 32'hDEAD_BEEF;
      dram[6] = 32'h1122_3344;
      srom[0] = 32'h1719_2051;
      srom[1] = 32'h1672_6992;
      srom[2] = 32'h0;
      srom[3] = 32'h0;
      for (int i = 0; i < 256; i++) m_dram[i] = 8'(dram[i / 4] >> (8 * (i % 4)));
      for (int i = 0; i < 16; i++)  m_srom[i] = 8'(srom[i / 4] >> (8 * (i % 4)));

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      do_op("LB 8",      0, 3'b000, 32'h8000_0008, 32'h0,          1, 32'hFFFF_FF88, 0);
      do_op("LBU 8",     0, 3'b100, 32'h8000_0008, 32'h0,          1, 32'h0000_0088, 0);
      do_op("SB 9",      1, 3'b000, 32'h8000_0009, 32'h0000_00AB,  1, 32'h0000_AB88, 0);
      do_op("LW 8",      0, 3'b010, 32'h8000_0008, 32'h0,          1, 32'h0000_AB88, 0);
      do_op("SH 12",     1, 3'b001, 32'h8000_0012, 32'h0000_1234,  1, 32'h1234_BEEF, 0);
      do_op("LH 12",     0, 3'b001, 32'h8000_0012, 32'h0,          1, 32'h0000_1234, 0);
      do_op("LHU 10",    0, 3'b101, 32'h8000_0010, 32'h0,          1, 32'h0000_BEEF, 0);
      do_op("LH 10",     0, 3'b001, 32'h8000_0010, 32'h0,          1, 32'hFFFF_BEEF, 0);
      do_op("LW rom0",   0, 3'b010, 32'h0010_0000, 32'h0,          1, 32'h1719_2051, 0);
      do_op("LW rom4",   0, 3'b010, 32'h0010_0004, 32'h0,          1, 32'h1672_6992, 0);
      do_op("SW rom",    1, 3'b010, 32'h0010_0000, 32'h1234_5678,  1, 32'h0,         1);
      do_op("LW mis",    0, 3'b010, 32'h8000_0002, 32'h0,          1, 32'h0,         1);
      do_op("SH mis",    1, 3'b001, 32'h8000_0001, 32'h0000_FFFF,  1, 32'h0,         1);
      do_op("LW unmap",  0, 3'b010, 32'h4000_0000, 32'h0,          1, 32'h0,         1);
      do_op("L f3 011",  0, 3'b011, 32'h8000_0008, 32'h0,          1, 32'h0,         1);
      do_op("S f3 100",  1, 3'b100, 32'h8000_0008, 32'h0,          1, 32'h0,         1);
      do_op("SW 20",     1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D,  1, 32'hCAFE_F00D, 0);
      do_op("LW 20",     0, 3'b010, 32'h8000_0020, 32'h0,          1, 32'hCAFE_F00D, 0);
      do_op("SB 23",     1, 3'b000, 32'h8000_0023, 32'h1234_5680,  1, 32'h80FE_F00D, 0);
      do_op("LB 23",     0, 3'b000, 32'h8000_0023, 32'h0,          1, 32'hFFFF_FF80, 0);
      do_op("LBU 22",    0, 3'b100, 32'h8000_0022, 32'h0,          1, 32'h0000_00FE, 0);
      do_op("LH 22",     0, 3'b001, 32'h8000_0022, 32'h0,          1, 32'hFFFF_80FE, 0);
      do_op("SH 20",     1, 3'b001, 32'h8000_0020, 32'hFFFF_7A7A,  1, 32'h80FE_7A7A, 0);
      do_op("LW 20b",    0, 3'b010, 32'h8000_0020, 32'h0,          1, 32'h80FE_7A7A, 0);
      do_op("LB 21",     0, 3'b000, 32'h8000_0021, 32'h0,          1, 32'h0000_007A, 0);

      // Reset asserted during the WR cycle of an SB must abort without writing
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h8000_001A;
      req_wdata  = 32'h0000_0055;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst rd cycle", mem_read, 1);
      @(negedge clk);
      check("rst wr cycle", mem_write, 1);
      rst_n = 1'b0;
      #1;
      check("rst wr gated", mem_write, 0);
      @(negedge clk);
      check_reset_outputs("rst abort");
      check("rst word kept", dram[6], 32'h1122_3344);
      rst_n = 1'b1;
      do_op("LW after rst", 0, 3'b010, 32'h8000_0018, 32'h0, 1, 32'h1122_3344, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
